masked_sbox_layer_seq: RTL

- Sequencer and share-register shell around NUM_SBOX parallel masked 4-bit S-box cores with HPC2 pipelined gadgets, at arbitrary security order.
- Replaces the fixed-latency free-running gated-clock scheme with explicit valid/ready handshakes on input, randomness and output.
- Holds input shares and fresh randomness stable for exactly LATENCY core cycles, then captures core output shares under a clock enable.
- Sits between the cipher round datapath, the PRNG and the externally instantiated masked S-box layer.

---
 rtl/masked_sbox_layer_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/masked_sbox_layer_seq.sv
// Handshake sequencer and share registers around NUM_SBOX masked 4-bit S-box cores.
// Optional macro FRESH_REFRESH_EN: consume a fresh randomness word on every RUN beat.
module masked_sbox_layer_seq #(
    parameter int SECURITY_ORDER = 2,
    parameter int NUM_SBOX       = 1,
    parameter int LATENCY        = 10,
    parameter int FRESH_W        = 39,
    localparam int SW            = (SECURITY_ORDER + 1) * 4 * NUM_SBOX,
    localparam int RW            = FRESH_W * NUM_SBOX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] in_data,
    input  logic          rnd_valid,
    output logic          rnd_ready,
    input  logic [RW-1:0] rnd_data,
    output logic [SW-1:0] core_in,
    output logic [RW-1:0] core_fresh,
    input  logic [SW-1:0] core_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_data,
    output logic          synch,
    output logic          busy
);

    localparam int CW = $clog2(LATENCY + 1);

`ifdef FRESH_REFRESH_EN
    localparam bit REFRESH = 1'b1;
`else
    localparam bit REFRESH = 1'b0;
`endif

    if (LATENCY < 1) begin : g_latency_check
        $error("masked_sbox_layer_seq: LATENCY must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [SW-1:0]   core_in_r, core_in_s;
    logic [RW-1:0]   core_fresh_r, core_fresh_s;
    logic [SW-1:0]   out_data_r, out_data_s;
    logic            synch_r, synch_s;
    logic            in_ready_r, in_ready_s;
    logic            rnd_ready_r, rnd_ready_s;
    logic            out_valid_r, out_valid_s;
    logic            busy_r, busy_s;
    logic            run_beat_s;

    // A RUN cycle only counts when randomness is being consumed in refresh mode.
    assign run_beat_s = REFRESH ? rnd_valid : 1'b1;

    // Next-state, counter and share-register update logic.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        core_in_s    = core_in_r;
        core_fresh_s = core_fresh_r;
        out_data_s   = out_data_r;
        synch_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    core_in_s = in_data;
                    state_s   = LOAD;
                end else begin
                    state_s   = IDLE;
                end
            end
            LOAD: begin
                if (rnd_valid) begin
                    core_fresh_s = rnd_data;
                    cnt_s        = CW'(LATENCY);
                    state_s      = RUN;
                end else begin
                    state_s      = LOAD;
                end
            end
            RUN: begin
                if (run_beat_s) begin
                    if (REFRESH) begin
                        core_fresh_s = rnd_data;
                    end else begin
                        core_fresh_s = core_fresh_r;
                    end
                    // cnt never reaches 0 inside RUN; <= 1 keeps the decrement from wrapping.
                    if (cnt_r <= CW'(1)) begin
                        out_data_s = core_out;
                        cnt_s      = '0;
                        synch_s    = 1'b1;
                        state_s    = DONE;
                    end else begin
                        cnt_s      = cnt_r - CW'(1);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            DONE: begin
                if (out_ready) begin
                    core_in_s    = '0;
                    core_fresh_s = '0;
                    state_s      = IDLE;
                end else begin
                    state_s      = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Handshake flags are decoded from the next state so they leave the block registered.
    always_comb begin
        in_ready_s  = (state_s == IDLE);
        out_valid_s = (state_s == DONE);
        busy_s      = (state_s != IDLE);
        if (REFRESH) begin
            rnd_ready_s = (state_s == LOAD) || (state_s == RUN);
        end else begin
            rnd_ready_s = (state_s == LOAD);
        end
    end

    // State, share and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            core_in_r    <= '0;
            core_fresh_r <= '0;
            out_data_r   <= '0;
            synch_r      <= 1'b0;
            in_ready_r   <= 1'b1;
            rnd_ready_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            core_in_r    <= core_in_s;
            core_fresh_r <= core_fresh_s;
            out_data_r   <= out_data_s;
            synch_r      <= synch_s;
            in_ready_r   <= in_ready_s;
            rnd_ready_r  <= rnd_ready_s;
            out_valid_r  <= out_valid_s;
            busy_r       <= busy_s;
        end
    end

    assign core_in    = core_in_r;
    assign core_fresh = core_fresh_r;
    assign out_data   = out_data_r;
    assign synch      = synch_r;
    assign in_ready   = in_ready_r;
    assign rnd_ready  = rnd_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;

endmodule
